// File: rtl/bus_mem_device.sv
// Word memory slave: a re/we level is accepted in IDLE and granted with a 1-cycle gnt pulse 1+Latency cycles later.
// Backpressure: requester holds re/we; dropping it during WAIT aborts, a request still held after gnt is not re-executed.
module bus_mem_device #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int Depth     = 1024,
    parameter int Latency   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] device_addr,
    input  logic                 device_re,
    input  logic                 device_we,
    input  logic [DataWidth-1:0] device_rdata,
    output logic [DataWidth-1:0] device_wdata,
    output logic                 device_gnt,
    output logic                 busy_o
);
    localparam int IdxW = $clog2(Depth);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_HOLD
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 op_we_q, op_we_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;

    logic [DataWidth-1:0] mem [Depth];

    logic                 req_one;
    logic                 req_none;
    logic                 enter_resp;
    logic                 op_sel;
    logic                 mem_we;
    logic [IdxW-1:0]      mem_idx;
    logic [DataWidth-1:0] mem_data;

    // Only the word index is decoded; the rest of the address aliases.
    logic unused_addr;
    assign unused_addr = ^device_addr;

    assign req_one  = device_re ^ device_we;
    assign req_none = !device_re && !device_we;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        op_we_d    = op_we_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        enter_resp = 1'b0;
        op_sel     = op_we_q;
        mem_idx    = idx_q;
        mem_data   = data_q;
        mem_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_one) begin
                    idx_d   = device_addr[IdxW+1:2];
                    op_we_d = device_we;
                    data_d  = device_rdata;
                    cnt_d   = 4'(Latency);
                    if (Latency == 0) begin
                        // Zero wait states: execute straight from the live request.
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                        op_sel     = device_we;
                        mem_idx    = device_addr[IdxW+1:2];
                        mem_data   = device_rdata;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (req_none) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (req_none) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp) begin
            if (op_sel) begin
                mem_we = 1'b1;
            end else begin
                rdata_d = mem[mem_idx];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            op_we_q <= 1'b0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            op_we_q <= op_we_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage survives reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_data;
        end
    end

    assign device_wdata = rdata_q;
    assign device_gnt   = (state_q == ST_RESP);
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_mem_device.sv
// Two devices (Latency 3 and Latency 0) checked against a transaction-level memory model.
module tb_bus_mem_device;
    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rd    [2];
    logic        re    [2];
    logic        we    [2];
    logic        gnt   [2];
    logic        busy  [2];

    logic [31:0] mem_m [2][DEPTH];
    logic [31:0] rd_m  [2];
    int          lat   [2];

    int checks = 0;
    int errors = 0;

    bus_mem_device #(.AddrWidth(32), .DataWidth(32), .Depth(DEPTH), .Latency(3)) dut_l3 (
        .clk_i(clk), .rst_i(rst_n), .device_addr(addr[0]), .device_re(re[0]),
        .device_we(we[0]), .device_rdata(wd[0]), .device_wdata(rd[0]),
        .device_gnt(gnt[0]), .busy_o(busy[0])
    );

    bus_mem_device #(.AddrWidth(32), .DataWidth(32), .Depth(DEPTH), .Latency(0)) dut_l0 (
        .clk_i(clk), .rst_i(rst_n), .device_addr(addr[1]), .device_re(re[1]),
        .device_we(we[1]), .device_rdata(wd[1]), .device_wdata(rd[1]),
        .device_gnt(gnt[1]), .busy_o(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction; hold = extra cycles the request stays high after gnt.
    task automatic txn(input int d, input bit w, input logic [31:0] a,
                       input logic [31:0] data, input int hold);
        int idx;
        idx = int'((a >> 2) % DEPTH);
        @(negedge clk);
        chk("idle_before", 32'(busy[d]), 32'd0);
        addr[d] = a;
        wd[d]   = data;
        re[d]   = !w;
        we[d]   = w;
        for (int k = 0; k <= lat[d]; k++) begin
            @(negedge clk);
            if (k == 0) begin
                addr[d] = $urandom;
                wd[d]   = $urandom;
            end
            if (k == lat[d]) begin
                if (w) mem_m[d][idx] = data;
                else   rd_m[d] = mem_m[d][idx];
            end
            chk("busy_txn", 32'(busy[d]), 32'd1);
            chk("gnt_txn", 32'(gnt[d]), 32'(k == lat[d]));
            chk("rdata_txn", rd[d], rd_m[d]);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("busy_hold", 32'(busy[d]), 32'd1);
            chk("gnt_hold", 32'(gnt[d]), 32'd0);
        end
        re[d] = 1'b0;
        we[d] = 1'b0;
        @(negedge clk);
        chk("busy_drop", 32'(busy[d]), 32'(hold == 0));
        chk("gnt_drop", 32'(gnt[d]), 32'd0);
        if (hold == 0) begin
            @(negedge clk);
            chk("busy_after", 32'(busy[d]), 32'd0);
        end
        chk("rdata_after", rd[d], rd_m[d]);
    endtask

    // Write on the Latency-3 device that is withdrawn after k+1 accepted cycles.
    task automatic abort_wr(input logic [31:0] a, input logic [31:0] data, input int k);
        @(negedge clk);
        chk("idle_before_abort", 32'(busy[0]), 32'd0);
        addr[0] = a;
        wd[0]   = data;
        we[0]   = 1'b1;
        for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            chk("busy_abort", 32'(busy[0]), 32'd1);
            chk("gnt_abort", 32'(gnt[0]), 32'd0);
        end
        we[0] = 1'b0;
        @(negedge clk);
        chk("idle_after_abort", 32'(busy[0]), 32'd0);
        chk("gnt_after_abort", 32'(gnt[0]), 32'd0);
        chk("rdata_abort", rd[0], rd_m[0]);
    endtask

    initial begin
        lat[0] = 3;
        lat[1] = 0;
        rst_n  = 1'b0;
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; wd[d] = '0; re[d] = 1'b0; we[d] = 1'b0; rd_m[d] = '0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_rdata", rd[d], 32'd0);
            chk("rst_gnt", 32'(gnt[d]), 32'd0);
            chk("rst_busy", 32'(busy[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Fill every word so later reads are defined.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                txn(d, 1'b1, 32'(i * 4), $urandom, 0);

        // Write then read back.
        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b1, 32'h10, 32'hDEADBEEF, 0);
            txn(d, 1'b0, 32'h10, 32'h0, 1);
            chk("readback", rd[d], 32'hDEADBEEF);
        end

        // Long-held request on Latency 0 executes once.
        txn(1, 1'b1, 32'h24, 32'h0BADF00D, 5);
        txn(1, 1'b0, 32'h24, 32'h0, 0);
        chk("held_once", rd[1], 32'h0BADF00D);

        // Aliasing (window is DEPTH*4 bytes) and ignored low bits.
        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b1, 32'h0000_0104, 32'h11111111, 0);
            txn(d, 1'b0, 32'h0000_0004, 32'h0, 0);
            chk("alias", rd[d], 32'h11111111);
            txn(d, 1'b0, 32'h0000_0006, 32'h0, 0);
            chk("lowbits", rd[d], 32'h11111111);
        end

        // Abort leaves memory alone; both-high never accepted.
        txn(0, 1'b1, 32'h20, 32'h5A5A0000, 0);
        abort_wr(32'h20, 32'hA5A5A5A5, 1);
        txn(0, 1'b0, 32'h20, 32'h0, 0);
        chk("abort_prior", rd[0], 32'h5A5A0000);
        @(negedge clk);
        re[0] = 1'b1;
        we[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("both_busy", 32'(busy[0]), 32'd0);
            chk("both_gnt", 32'(gnt[0]), 32'd0);
        end
        re[0] = 1'b0;
        we[0] = 1'b0;

        // Read result survives a following write.
        for (int d = 0; d < 2; d++) begin
            txn(d, 1'b1, 32'h40, 32'h12345678, 0);
            txn(d, 1'b0, 32'h40, 32'h0, 0);
            txn(d, 1'b1, 32'h44, $urandom, 0);
            chk("read_kept", rd[d], 32'h12345678);
        end

        // Reset during WAIT of a write.
        txn(0, 1'b1, 32'h80, 32'hCAFE0001, 0);
        txn(0, 1'b0, 32'h80, 32'h0, 0);
        @(negedge clk);
        addr[0] = 32'h80;
        wd[0]   = 32'hFFFF0002;
        we[0]   = 1'b1;
        @(negedge clk);
        chk("wait_busy", 32'(busy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt[0]), 32'd0);
        chk("arst_busy", 32'(busy[0]), 32'd0);
        chk("arst_rdata", rd[0], 32'd0);
        rd_m[0] = '0;
        rd_m[1] = '0;
        we[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        txn(0, 1'b0, 32'h80, 32'h0, 0);
        chk("arst_mem_kept", rd[0], 32'hCAFE0001);

        // Random traffic against the model.
        for (int n = 0; n < 200; n++) begin
            int d;
            d = int'($urandom_range(1, 0));
            if (d == 0 && $urandom_range(7, 0) == 0)
                abort_wr($urandom, $urandom, int'($urandom_range(2, 0)));
            else
                txn(d, 1'($urandom_range(1, 0)), $urandom, $urandom, int'($urandom_range(2, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
